// File: rtl/serial_adder_if.sv
// Operand/result bundle for serial_adder; the ovf wire exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(parameter int unsigned WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;

   modport master (output start, a_in, b_in, input busy, done, sum, cout, ovf);
   modport slave  (input start, a_in, b_in, output busy, done, sum, cout, ovf);
`else
   modport master (output start, a_in, b_in, input busy, done, sum, cout);
   modport slave  (input start, a_in, b_in, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one bit per clock through two half adders and an OR.
// Define SERIAL_ADDER_OVF_EN to add the signed overflow flag (ovf).
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst,
   serial_adder_if.slave  bus
);
   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sr, b_sr, res_sr, sum_q;
   logic [CW-1:0]    cnt;
   logic             carry, cout_q, busy_q, done_q;
   logic             s1_c, c1_c, bit_c, carry_nxt_c, last_c;
`ifdef SERIAL_ADDER_OVF_EN
   logic             a_msb, b_msb, ovf_q;
`endif

   // One-bit add stage on the current LSBs
   always_comb begin
      s1_c        = a_sr[0] ^ b_sr[0];
      c1_c        = a_sr[0] & b_sr[0];
      bit_c       = s1_c ^ carry;
      carry_nxt_c = c1_c | (s1_c & carry);
      last_c      = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = SHIFT;
         SHIFT:   if (last_c)    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath; sum/cout update only on the final bit so they hold between operations
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         sum_q  <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         ovf_q  <= 1'b0;
`endif
      end else begin
         busy_q <= (state_nxt == SHIFT);
         done_q <= (state_nxt == DONE);
         case (state)
            IDLE: begin
               if (bus.start) begin
                  a_sr   <= bus.a_in;
                  b_sr   <= bus.b_in;
                  res_sr <= '0;
                  carry  <= 1'b0;
                  cnt    <= '0;
`ifdef SERIAL_ADDER_OVF_EN
                  a_msb  <= bus.a_in[WIDTH-1];
                  b_msb  <= bus.b_in[WIDTH-1];
`endif
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               res_sr <= {bit_c, res_sr[WIDTH-1:1]};
               carry  <= carry_nxt_c;
               cnt    <= cnt + CW'(1);
               if (last_c) begin
                  sum_q  <= {bit_c, res_sr[WIDTH-1:1]};
                  cout_q <= carry_nxt_c;
`ifdef SERIAL_ADDER_OVF_EN
                  ovf_q  <= (a_msb == b_msb) && (bit_c != a_msb);
`endif
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, corner sequences, random ops vs arithmetic model.
module tb_serial_adder;
   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   serial_adder_if #(.WIDTH(W)) bif ();
   serial_adder #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bif.slave));

   always #5 clk = ~clk;

   typedef struct {
      string    name;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] s;
      logic       c;
      logic       o;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
      end
   endtask

   // Signed/unsigned reference using plain integer arithmetic
   function automatic void ref_add(input logic [7:0] a, input logic [7:0] b,
                                   output logic [7:0] s, output logic c, output logic o);
      int unsigned t;
      int          r;
      t = int'(a) + int'(b);
      s = 8'(t % 256);
      c = (t >= 256);
      r = int'($signed(a)) + int'($signed(b));
      o = (r > 127) || (r < -128);
   endfunction

   // Entered #1 after an edge with the DUT idle; returns in the done cycle (or on timeout)
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit hold, input bit scramble,
                         output int edges, output int bcnt);
      bif.a_in  = a;
      bif.b_in  = b;
      bif.start = 1'b1;
      @(posedge clk); #1;
      if (!hold) bif.start = 1'b0;
      if (scramble) begin
         bif.a_in = 8'hFF;
         bif.b_in = 8'hFF;
      end
      edges = 0;
      bcnt  = 0;
      while (!bif.done && edges < 40) begin
         if (bif.busy) bcnt++;
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic check_result(input string nm, input int edges, input int bcnt,
                               input logic [7:0] s, input logic c, input logic o);
      chk({nm, " latency"}, 32'(edges), 32'(8));
      chk({nm, " busy_cycles"}, 32'(bcnt), 32'(8));
      chk({nm, " sum"}, 32'(bif.sum), 32'(s));
      chk({nm, " cout"}, 32'(bif.cout), 32'(c));
`ifdef SERIAL_ADDER_OVF_EN
      chk({nm, " ovf"}, 32'(bif.ovf), 32'(o));
`endif
   endtask

   initial begin
      int          edges, bcnt, dcnt;
      logic [7:0]  ra, rb, rs, held;
      logic        rc, ro;

      vecs[0] = '{"5a+3c", 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
      vecs[1] = '{"ff+01", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{"7f+01", 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
      vecs[3] = '{"80+80", 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
      vecs[4] = '{"aa+55", 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
      vecs[5] = '{"00+00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[6] = '{"ff+ff", 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};

      rst = 1'b1; bif.start = 1'b0; bif.a_in = '0; bif.b_in = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset sum", 32'(bif.sum), 32'(0));
      chk("reset cout", 32'(bif.cout), 32'(0));
      chk("reset busy", 32'(bif.busy), 32'(0));
      chk("reset done", 32'(bif.done), 32'(0));
`ifdef SERIAL_ADDER_OVF_EN
      chk("reset ovf", 32'(bif.ovf), 32'(0));
`endif
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed table, each followed by a hold check with start low and noisy operands
      for (int i = 0; i < 7; i++) begin
         run_op(vecs[i].a, vecs[i].b, 1'b0, 1'b0, edges, bcnt);
         check_result(vecs[i].name, edges, bcnt, vecs[i].s, vecs[i].c, vecs[i].o);
         bif.a_in = 8'($urandom);
         bif.b_in = 8'($urandom);
         repeat (3) @(posedge clk);
         #1;
         chk({vecs[i].name, " hold sum"}, 32'(bif.sum), 32'(vecs[i].s));
         chk({vecs[i].name, " hold done"}, 32'(bif.done), 32'(0));
      end

      // Operands change right after acceptance
      run_op(8'h01, 8'h02, 1'b0, 1'b1, edges, bcnt);
      check_result("late_operand", edges, bcnt, 8'h03, 1'b0, 1'b0);
      @(posedge clk); #1;

      // start held high across the whole operation
      run_op(8'h12, 8'h34, 1'b1, 1'b0, edges, bcnt);
      check_result("start_held", edges, bcnt, 8'h46, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("start_held idle done", 32'(bif.done), 32'(0));
      chk("start_held idle busy", 32'(bif.busy), 32'(0));
      @(posedge clk); #1;
      chk("start_held restart busy", 32'(bif.busy), 32'(1));
      bif.start = 1'b0;
      edges = 0;
      while (!bif.done && edges < 40) begin
         @(posedge clk); #1;
         edges++;
      end
      chk("start_held second latency", 32'(edges), 32'(8));
      chk("start_held second sum", 32'(bif.sum), 32'(8'h46));
      @(posedge clk); #1;

      // Reset on the 4th SHIFT edge
      bif.a_in = 8'hAA; bif.b_in = 8'h55; bif.start = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midreset busy", 32'(bif.busy), 32'(0));
      chk("midreset sum", 32'(bif.sum), 32'(0));
      chk("midreset cout", 32'(bif.cout), 32'(0));
      dcnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (bif.done) dcnt++;
         @(posedge clk); #1;
      end
      chk("midreset no done", 32'(dcnt), 32'(0));

      // start together with reset is ignored
      bif.start = 1'b1; rst = 1'b1;
      @(posedge clk); #1;
      bif.start = 1'b0; rst = 1'b0;
      chk("rst_start busy", 32'(bif.busy), 32'(0));
      @(posedge clk); #1;
      chk("rst_start still idle", 32'(bif.busy), 32'(0));

      // Random operations against the arithmetic model
      held = 8'h00;
      for (int n = 0; n < 40; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         ref_add(ra, rb, rs, rc, ro);
         run_op(ra, rb, 1'b0, 1'b0, edges, bcnt);
         check_result("random", edges, bcnt, rs, rc, ro);
         held = rs;
         @(posedge clk); #1;
         chk("random hold sum", 32'(bif.sum), 32'(held));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, is the operand width in bits; legal range 2..32.
REQ-002 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  is the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  is the operation request, sampled only in IDLE.
REQ-005 a_in  input  WIDTH  is operand A, captured on the accepting edge.
REQ-006 b_in  input  WIDTH  is operand B, captured on the accepting edge.
REQ-007 busy  output  1  is high while in SHIFT.
REQ-008 done  output  1  is a one-cycle completion pulse, high only in DONE.
REQ-009 sum  output  WIDTH  is the result (A+B) mod 2^WIDTH.
REQ-010 cout  output  1  is the carry out of bit WIDTH-1.
REQ-011 ovf  output  1  is the signed overflow flag; present only when SERIAL_ADDER_OVF_EN is defined.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 In IDLE with start=1, on the edge the block SHALL load a_in and b_in into shift registers, clear the carry flop and the bit counter, and enter SHIFT.
REQ-014 In IDLE with start=0, the block SHALL remain in IDLE and hold sum and cout.
REQ-015 Each SHIFT edge SHALL process one bit, LSB first: s1=a0^b0, c1=a0&b0, bit=s1^carry, carry<=c1|(s1&carry); this is two cascaded half-adder stages plus an OR.
REQ-016 Each SHIFT edge SHALL shift both operand registers right by one, shift the result bit into the MSB of the result register, and increment the counter.
REQ-017 On the edge that processes bit WIDTH-1, the block SHALL enter DONE, and cout SHALL take the final carry.
REQ-018 done SHALL go high WIDTH edges after the edge that sampled start (8 for the default), for exactly one cycle; the block then returns to IDLE unconditionally.
REQ-019 sum and cout SHALL be valid from the DONE cycle and held stable until the next accepted start.
REQ-020 start SHALL be ignored in SHIFT and in DONE; the operation in progress is not disturbed.
REQ-021 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL never wrap during an operation.
REQ-022 a_in and b_in changes after the accepting edge SHALL have no effect on the result.

Reset
REQ-023 With rst=1 on an edge, the block SHALL enter IDLE and clear all registers: sum=0, cout=0, busy=0, done=0, counter=0 and carry=0; ovf=0 when present.
REQ-024 rst SHALL take priority over start and over any in-progress SHIFT; a reset mid-operation discards the partial result and no done pulse follows.
REQ-025 start sampled on the same edge as rst=1 SHALL be ignored.

Configuration
REQ-026 With SERIAL_ADDER_OVF_EN defined, port ovf SHALL exist and SHALL be registered in DONE as (a_msb==b_msb)&&(sum_msb!=a_msb), using the captured operand MSBs; it is held with sum.
REQ-027 Without SERIAL_ADDER_OVF_EN, the ovf port and its MSB capture logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 WIDTH=8, reset 2 cycles, then start with a_in=0x5A and b_in=0x3C: done pulses exactly 8 edges later, with sum=0x96, cout=0 and busy high for 8 cycles.
REQ-029 a_in=0xFF, b_in=0x01: sum=0x00 and cout=1; ovf=0 when enabled.
REQ-030 With SERIAL_ADDER_OVF_EN defined, a_in=0x7F and b_in=0x01: sum=0x80, cout=0 and ovf=1; then 0x80+0x80: sum=0x00, cout=1 and ovf=1.
REQ-031 A start held high throughout a 0x12+0x34 operation: exactly one done pulse with sum=0x46, then a new operation begins from IDLE on the next edge with start still high.
REQ-032 rst asserted on the 4th SHIFT edge of 0xAA+0x55: the next cycle shows busy=0, sum=0 and cout=0, and no done pulse appears within 20 cycles.
REQ-033 Operands changed to 0xFF/0xFF one cycle after the accepting edge of 0x01+0x02: the result is sum=0x03 and cout=0.
